// File: rtl/fib_table.sv
// rtl/fib_table.sv - FIB prefix table with longest-prefix lookup and PIT offer/stream path
// Optional feature: FIB_DEFAULT_ROUTE_EN (misses return a 0/0 default route with a strobe)
module fib_table #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pit_in_prefix,
    input  logic [5:0]  pit_in_len,
    input  logic        fib_out_bit,
    input  logic        start_send_to_pit,
    input  logic        rejected,
    input  logic [5:0]  data_in_len,
    input  logic [63:0] data_in_prefix,
    input  logic        data_ready,
    input  logic [7:0]  data_in,
    output logic [5:0]  pit_out_len,
    output logic [63:0] pit_out_prefix,
    output logic        prefix_ready,
    output logic [7:0]  out_data,
    output logic [63:0] longest_matching_prefix,
    output logic [5:0]  longest_matching_prefix_len,
    output logic        clk_out
);
    localparam int IW = $clog2(ENTRIES);

    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_STREAM} state_e;

    function automatic logic [63:0] len_mask(input logic [5:0] l);
        return ~({64{1'b1}} >> l);
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [63:0]        pfx_q [ENTRIES];
    logic [5:0]         len_q [ENTRIES];
    logic [IW-1:0]      rr_q;
    logic               fib_prev_q, pend_q;
    logic [63:0]        qpfx_q;
    logic [5:0]         qlen_q;
    state_e             state_q, state_d;
    logic [63:0]        pit_out_prefix_q, lmp_q;
    logic [5:0]         pit_out_len_q, lmpl_q;
    logic [7:0]         out_data_q;
    logic               clk_out_q;

    // Lookup: strict '>' keeps the lowest index on equal lengths
    logic        hit;
    logic [63:0] best_pfx;
    logic [5:0]  best_len;
    always_comb begin
        hit      = 1'b0;
        best_pfx = '0;
        best_len = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && len_q[i] <= qlen_q &&
                (qpfx_q & len_mask(len_q[i])) == pfx_q[i] &&
                (!hit || len_q[i] > best_len)) begin
                hit      = 1'b1;
                best_pfx = pfx_q[i];
                best_len = len_q[i];
            end
        end
    end

    logic [63:0]   ins_pfx;
    logic          dup, free_found, accept;
    logic [IW-1:0] free_idx, ins_idx;
    always_comb begin
        ins_pfx    = pit_out_prefix_q & len_mask(pit_out_len_q);
        dup        = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && pfx_q[i] == ins_pfx && len_q[i] == pit_out_len_q)
                dup = 1'b1;
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        ins_idx = free_found ? free_idx : rr_q;
        accept  = (state_q == S_OFFER) && start_send_to_pit && !rejected;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (data_ready) state_d = S_OFFER;
            S_OFFER:  if (rejected) state_d = S_IDLE;
                      else if (start_send_to_pit) state_d = S_STREAM;
            S_STREAM: if (!data_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q          <= '0;
            rr_q             <= '0;
            fib_prev_q       <= 1'b0;
            pend_q           <= 1'b0;
            qpfx_q           <= '0;
            qlen_q           <= '0;
            state_q          <= S_IDLE;
            pit_out_prefix_q <= '0;
            pit_out_len_q    <= '0;
            out_data_q       <= '0;
            lmp_q            <= '0;
            lmpl_q           <= '0;
            clk_out_q        <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                pfx_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            fib_prev_q <= fib_out_bit;
            pend_q     <= fib_out_bit & ~fib_prev_q;
            if (fib_out_bit && !fib_prev_q) begin
                qpfx_q <= pit_in_prefix;
                qlen_q <= pit_in_len;
            end
            clk_out_q <= 1'b0;
            if (pend_q) begin
                if (hit) begin
                    lmp_q     <= best_pfx;
                    lmpl_q    <= best_len;
                    clk_out_q <= 1'b1;
                end
`ifdef FIB_DEFAULT_ROUTE_EN
                else begin
                    lmp_q     <= '0;
                    lmpl_q    <= '0;
                    clk_out_q <= 1'b1;
                end
`else
`endif
            end
            state_q <= state_d;
            if (state_q == S_IDLE && data_ready) begin
                pit_out_prefix_q <= data_in_prefix;
                pit_out_len_q    <= data_in_len;
            end
            if (state_q == S_STREAM && data_ready)
                out_data_q <= data_in;
            // Install shares the edge with the lookup result, which reads the old table
            if (accept && !dup) begin
                valid_q[ins_idx] <= 1'b1;
                pfx_q[ins_idx]   <= ins_pfx;
                len_q[ins_idx]   <= pit_out_len_q;
                if (!free_found)
                    rr_q <= rr_q + 1'b1;
            end
        end
    end

    assign prefix_ready                = (state_q == S_OFFER);
    assign pit_out_prefix              = pit_out_prefix_q;
    assign pit_out_len                 = pit_out_len_q;
    assign out_data                    = out_data_q;
    assign longest_matching_prefix     = lmp_q;
    assign longest_matching_prefix_len = lmpl_q;
    assign clk_out                     = clk_out_q;
endmodule

// File: tb/tb_fib_table.sv
// tb/tb_fib_table.sv - self-checking bench for fib_table with a behavioural table model
module tb_fib_table;
    localparam int ENTRIES = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pit_in_prefix, data_in_prefix;
    logic [5:0]  pit_in_len, data_in_len;
    logic        fib_out_bit, start_send_to_pit, rejected, data_ready;
    logic [7:0]  data_in;
    logic [5:0]  pit_out_len, longest_matching_prefix_len;
    logic [63:0] pit_out_prefix, longest_matching_prefix;
    logic        prefix_ready, clk_out;
    logic [7:0]  out_data;

    fib_table #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst),
        .pit_in_prefix(pit_in_prefix), .pit_in_len(pit_in_len),
        .fib_out_bit(fib_out_bit), .start_send_to_pit(start_send_to_pit),
        .rejected(rejected), .data_in_len(data_in_len),
        .data_in_prefix(data_in_prefix), .data_ready(data_ready),
        .data_in(data_in), .pit_out_len(pit_out_len),
        .pit_out_prefix(pit_out_prefix), .prefix_ready(prefix_ready),
        .out_data(out_data), .longest_matching_prefix(longest_matching_prefix),
        .longest_matching_prefix_len(longest_matching_prefix_len),
        .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: table as plain arrays, incoming path as a mode number
    bit          m_valid [ENTRIES];
    logic [63:0] m_pfx [ENTRIES];
    int          m_len [ENTRIES];
    int          m_rr, m_mode, m_olen, m_qlen, m_lmpl;
    bit          m_prev, m_pend, m_strobe;
    logic [63:0] m_opfx, m_qpfx, m_lmp;
    logic [7:0]  m_out;

    function automatic logic [63:0] top_bits(input logic [63:0] v, input int l);
        return (l == 0) ? 64'h0 : (v >> (64 - l)) << (64 - l);
    endfunction

    task automatic model_step();
        int best, slot;
        logic [63:0] mp;
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            m_rr = 0; m_mode = 0; m_olen = 0; m_qlen = 0; m_lmpl = 0;
            m_prev = 0; m_pend = 0; m_strobe = 0;
            m_opfx = 0; m_qpfx = 0; m_lmp = 0; m_out = 0;
            return;
        end
        m_strobe = 0;
        if (m_pend) begin
            best = -1;
            for (int i = 0; i < ENTRIES; i++)
                if (m_valid[i] && m_len[i] <= m_qlen &&
                    top_bits(m_qpfx, m_len[i]) == m_pfx[i] &&
                    (best < 0 || m_len[i] > m_len[best]))
                    best = i;
            if (best >= 0) begin
                m_lmp = m_pfx[best]; m_lmpl = m_len[best]; m_strobe = 1;
            end else begin
`ifdef FIB_DEFAULT_ROUTE_EN
                m_lmp = 0; m_lmpl = 0; m_strobe = 1;
`endif
            end
        end
        m_pend = fib_out_bit && !m_prev;
        if (m_pend) begin m_qpfx = pit_in_prefix; m_qlen = int'(pit_in_len); end
        m_prev = fib_out_bit;
        case (m_mode)
            0: if (data_ready) begin m_opfx = data_in_prefix; m_olen = int'(data_in_len); m_mode = 1; end
            1: if (rejected) m_mode = 0;
               else if (start_send_to_pit) begin
                   m_mode = 2;
                   mp = top_bits(m_opfx, m_olen);
                   slot = -1;
                   for (int i = 0; i < ENTRIES; i++)
                       if (m_valid[i] && m_pfx[i] == mp && m_len[i] == m_olen) slot = -2;
                   if (slot == -1)
                       for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
                   if (slot == -1) begin slot = m_rr; m_rr = (m_rr + 1) % ENTRIES; end
                   if (slot >= 0) begin m_valid[slot] = 1; m_pfx[slot] = mp; m_len[slot] = m_olen; end
               end
            default: if (data_ready) m_out = data_in; else m_mode = 0;
        endcase
    endtask

    always begin
        @(posedge clk);
        #1;
        model_step();
        chk("clk_out", {63'b0, clk_out}, {63'b0, m_strobe});
        chk("lmp", longest_matching_prefix, m_lmp);
        chk("lmp_len", {58'b0, longest_matching_prefix_len}, 64'(m_lmpl));
        chk("prefix_ready", {63'b0, prefix_ready}, {63'b0, m_mode == 1});
        chk("pit_out_prefix", pit_out_prefix, m_opfx);
        chk("pit_out_len", {58'b0, pit_out_len}, 64'(m_olen));
        chk("out_data", {56'b0, out_data}, {56'b0, m_out});
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 0; fib_out_bit = 0; start_send_to_pit = 0; rejected = 0; data_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic install(input logic [63:0] p, input logic [5:0] l, input logic rej);
        @(negedge clk);
        data_ready = 1; data_in_prefix = p; data_in_len = l;
        @(negedge clk);
        data_ready = 0; start_send_to_pit = 1; rejected = rej;
        @(negedge clk);
        start_send_to_pit = 0; rejected = 0;
        @(negedge clk);
    endtask

    task automatic lookup(input logic [63:0] p, input logic [5:0] l,
                          output logic hit, output logic [63:0] rp, output logic [5:0] rl);
        @(negedge clk);
        pit_in_prefix = p; pit_in_len = l; fib_out_bit = 1;
        hit = 0; rp = 'x; rl = 'x;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            if (clk_out) begin hit = 1; rp = longest_matching_prefix; rl = longest_matching_prefix_len; end
        end
        @(negedge clk);
        fib_out_bit = 0;
    endtask

    task automatic expect_miss(input string nm, input logic hit, input logic [63:0] rp, input logic [5:0] rl);
`ifdef FIB_DEFAULT_ROUTE_EN
        chk({nm, "_strobe"}, {63'b0, hit}, 64'd1);
        chk({nm, "_pfx"}, rp, 64'h0);
        chk({nm, "_len"}, {58'b0, rl}, 64'd0);
`else
        chk({nm, "_strobe"}, {63'b0, hit}, 64'd0);
`endif
    endtask

    logic        h;
    logic [63:0] rp;
    logic [5:0]  rl;

    initial begin
        rst = 0; fib_out_bit = 0; start_send_to_pit = 0; rejected = 0; data_ready = 0;
        pit_in_prefix = 0; pit_in_len = 0; data_in_prefix = 0; data_in_len = 0; data_in = 0;
        repeat (3) @(negedge clk);
        chk("reset_clk_out", {63'b0, clk_out}, 64'd0);
        chk("reset_lmp", longest_matching_prefix, 64'h0);
        chk("reset_prefix_ready", {63'b0, prefix_ready}, 64'd0);
        rst = 1;

        lookup(64'h0000FFFF0000FFFF, 6'd48, h, rp, rl);
        expect_miss("A_empty", h, rp, rl);

        install(64'h0000FFFF00000000, 6'd32, 1'b0);
        lookup(64'h0000FFFF0000FFFF, 6'd48, h, rp, rl);
        chk("B_hit", {63'b0, h}, 64'd1);
        chk("B_pfx", rp, 64'h0000FFFF00000000);
        chk("B_len", {58'b0, rl}, 64'd32);

        install(64'h123456789ABCDEF0, 6'd16, 1'b0);
        install(64'h123456789ABCDEF0, 6'd32, 1'b0);
        lookup(64'h123456789ABCDEF0, 6'd48, h, rp, rl);
        chk("C48_pfx", rp, 64'h1234567800000000);
        chk("C48_len", {58'b0, rl}, 64'd32);
        lookup(64'h123456789ABCDEF0, 6'd24, h, rp, rl);
        chk("C24_pfx", rp, 64'h1234000000000000);
        chk("C24_len", {58'b0, rl}, 64'd16);

        install(64'hAB00000000000000, 6'd8, 1'b1);
        lookup(64'hAB00000000000000, 6'd8, h, rp, rl);
        expect_miss("D_reject", h, rp, rl);

        // Reset between capture and result edges: no strobe, table cleared
        @(negedge clk);
        pit_in_prefix = 64'h0000FFFF0000FFFF; pit_in_len = 6'd48; fib_out_bit = 1;
        @(negedge clk);
        rst = 0; fib_out_bit = 0;
        @(posedge clk);
        #2;
        chk("midreset_clk_out", {63'b0, clk_out}, 64'd0);
        @(negedge clk);
        rst = 1;
        lookup(64'h0000FFFF0000FFFF, 6'd48, h, rp, rl);
        expect_miss("midreset_cleared", h, rp, rl);

        // Stream: byte offered during OFFER is dropped, then A5, 5A follow
        do_reset();
        @(negedge clk);
        data_ready = 1; data_in_prefix = 64'hC0DE000000000000; data_in_len = 6'd16; data_in = 8'h77;
        @(negedge clk);
        start_send_to_pit = 1;
        @(posedge clk);
        #2;
        chk("E_offer_drop", {56'b0, out_data}, 64'h0);
        @(negedge clk);
        start_send_to_pit = 0; data_in = 8'hA5;
        @(posedge clk);
        #2;
        chk("E_byte0", {56'b0, out_data}, 64'hA5);
        @(negedge clk);
        data_in = 8'h5A;
        @(posedge clk);
        #2;
        chk("E_byte1", {56'b0, out_data}, 64'h5A);
        @(negedge clk);
        data_ready = 0;
        @(negedge clk);

        do_reset();
        for (int i = 0; i <= ENTRIES; i++)
            install({8'(i + 1), 56'h0}, 6'd8, 1'b0);
        lookup(64'h0100000000000000, 6'd8, h, rp, rl);
        expect_miss("E_slot0_replaced", h, rp, rl);
        lookup(64'h0900000000000000, 6'd8, h, rp, rl);
        chk("E_new_pfx", rp, 64'h0900000000000000);
        lookup(64'h0255000000000000, 6'd16, h, rp, rl);
        chk("E_keep_pfx", rp, 64'h0200000000000000);
        chk("E_keep_len", {58'b0, rl}, 64'd8);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fib_table.md
FIB_TABLE -- requirements
Module: fib_table

Interface
REQ-001 Parameter ENTRIES, default 8, meaning number of FIB table entries; must be a power of two, 2..16.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- pit_in_prefix  in  64  interest name prefix from the PIT, MSB-aligned.
- pit_in_len  in  6  interest prefix length in bits.
- fib_out_bit  in  1  lookup request level.
- start_send_to_pit  in  1  PIT accepts the offered data prefix.
- rejected  in  1  PIT refuses the offered data prefix.
- data_in_len  in  6  incoming data prefix length in bits.
- data_in_prefix  in  64  incoming data prefix, MSB-aligned.
- data_ready  in  1  incoming data packet present / byte valid.
- data_in  in  8  incoming payload byte.
- pit_out_len  out  6  offered prefix length.
- pit_out_prefix  out  64  offered prefix.
- prefix_ready  out  1  offer pending to the PIT.
- out_data  out  8  payload byte forwarded to the PIT.
- longest_matching_prefix  out  64  lookup result prefix.
- longest_matching_prefix_len  out  6  lookup result length.
- clk_out  out  1  one-cycle lookup-result strobe.

Function
REQ-003 The table SHALL hold ENTRIES entries, each with a valid bit, a 64-bit prefix and a 6-bit length; stored prefix bits below the length SHALL be zero.
REQ-004 An entry of length L SHALL match a query of length Q when L <= Q and bits [63:64-L] are equal; an entry with L = 0 SHALL match any query.
REQ-005 A lookup SHALL start on a 0->1 transition of fib_out_bit, sampled at a rising edge, capturing pit_in_prefix and pit_in_len; holding fib_out_bit high SHALL NOT retrigger.
REQ-006 On the edge after capture, the block SHALL register the longest valid match onto longest_matching_prefix and longest_matching_prefix_len, and SHALL pulse clk_out high for exactly one cycle.
- Ties SHALL resolve to the lowest index.
- Outputs SHALL hold until the next lookup.
REQ-007 The incoming path SHALL be a state machine with states IDLE, OFFER and STREAM.
- IDLE: when data_ready = 1, latch data_in_prefix and data_in_len into pit_out_prefix and pit_out_len, then go to OFFER.
- OFFER: hold prefix_ready = 1. On start_send_to_pit go to STREAM. On rejected go to IDLE. If both are high, rejected wins.
- STREAM: out_data <= data_in every cycle that data_ready = 1. When data_ready = 0, go to IDLE. prefix_ready = 0.
REQ-008 When start_send_to_pit is accepted in OFFER, the latched prefix and length SHALL be installed in the table, with low bits masked.
- If an identical entry exists, no change.
- Otherwise use the lowest invalid slot.
- If the table is full, replace at a round-robin pointer that wraps from ENTRIES-1 to 0.
REQ-009 A lookup and an install in the same cycle SHALL see the pre-install table.
REQ-010 Bytes arriving on data_in while the machine is in OFFER SHALL be discarded.

Reset
REQ-011 With rst low, all of the following SHALL be zero: entry valid bits, replacement pointer, every output, and the edge-detect register. The incoming state machine SHALL be in IDLE.
REQ-012 Reset asserted mid-lookup or mid-stream SHALL abort the operation with no strobe and no install.

Configuration
REQ-013 Macro FIB_DEFAULT_ROUTE_EN SHALL control lookup misses.
- Defined: a miss SHALL return prefix 0 and length 0, with clk_out pulsed.
- Undefined: a miss SHALL pulse no clk_out and leave the result outputs unchanged.

Verification
REQ-014 Scenario A, empty table: reset, then fib_out_bit rises with prefix 64'h0000FFFF0000FFFF and length 48.
- With the macro defined: clk_out pulses once, result is 0/0.
- With the macro undefined: no pulse.
REQ-015 Scenario B, install then match: data_ready with prefix 64'h0000FFFF00000000 length 32, then start_send_to_pit, then lookup as in Scenario A -> result 64'h0000FFFF00000000 / 32, one cycle after capture.
REQ-016 Scenario C, longest match: install lengths 16 and 32 of the same prefix; lookup length 48 -> length 32 wins; lookup length 24 -> length 16 wins.
REQ-017 Scenario D, reject: offer, then rejected and start_send_to_pit high together -> return to IDLE, no install, a later lookup misses.
REQ-018 Scenario E, streaming and replacement:
- Accept, then stream bytes 0xA5, 0x5A -> out_data follows one cycle later.
- Installing ENTRIES+1 distinct prefixes overwrites slot 0.
